dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its neighbours.
package dmem_pkg;

  // Load size codes (insn[14:12]); the memory applies the sign/zero extension.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store size codes.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    S_SHARED = 1'b0,
    S_LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/grant/return signals of the CPU and DMA ports plus the memory-side bus.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [2:0]            cpu_funct3;
  logic                  cpu_gnt;
  logic                  cpu_stall;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  dma_req;
  logic                  dma_we;
  logic                  dma_lock;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic [2:0]            dma_funct3;
  logic                  dma_gnt;
  logic                  dma_rvalid;
  logic [DATA_WIDTH-1:0] dma_rdata;

  logic                  mem_read_en;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [2:0]            mem_funct3;
  logic [DATA_WIDTH-1:0] mem_data_out;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata, dma_funct3,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_read_en, mem_write_en, mem_address, mem_data_in, mem_funct3,
    input  mem_data_out
  );

  // Requester/memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata, dma_funct3,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_read_en, mem_write_en, mem_address, mem_data_in, mem_funct3,
    output mem_data_out
  );

endinterface

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the single-port data memory: CPU priority, DMA starvation
// limit, bounded locked DMA bursts, and read-data routing to the issuing port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 8
) (
  input  logic           i_clock,
  input  logic           i_reset,
  dmem_arbiter_if.slave  io_bus
);

  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BCW = $clog2(BURST_MAX + 1);
  localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_LIMIT);
  localparam logic [BCW-1:0] BURST_TOP  = BCW'(BURST_MAX);

  arb_state_t     r_state;
  logic [SCW-1:0] r_starve_cnt;
  logic [BCW-1:0] r_burst_cnt;
  logic           r_rd_pend;
  port_t          r_rd_owner;

  logic w_cpu_gnt;
  logic w_dma_gnt;
  logic w_cpu_rd;
  logic w_dma_rd;

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_SHARED: begin
          if (io_bus.dma_req && (!io_bus.cpu_req || (r_starve_cnt == STARVE_TOP)))
            w_dma_gnt = 1'b1;
          else if (io_bus.cpu_req)
            w_cpu_gnt = 1'b1;
        end
        S_LOCKED: begin
          if ((r_burst_cnt == BURST_TOP) && io_bus.cpu_req)
            w_cpu_gnt = 1'b1;
          else if (io_bus.dma_req)
            w_dma_gnt = 1'b1;
          else if (io_bus.cpu_req)
            w_cpu_gnt = 1'b1;
        end
        default: begin
          w_cpu_gnt = 1'b0;
          w_dma_gnt = 1'b0;
        end
      endcase
    end
  end

  assign w_cpu_rd = w_cpu_gnt && !io_bus.cpu_we;
  assign w_dma_rd = w_dma_gnt && !io_bus.dma_we;

  // Lock FSM, starvation/burst counters and read-return tag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_SHARED;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= PORT_CPU;
    end else begin
      case (r_state)
        S_SHARED: begin
          if (w_dma_gnt && io_bus.dma_lock) begin
            r_state     <= S_LOCKED;
            r_burst_cnt <= BCW'(1);
          end
        end
        S_LOCKED: begin
          // A CPU grant at a full burst count is always the forced slot.
          if (w_cpu_gnt && (r_burst_cnt == BURST_TOP)) begin
            r_burst_cnt <= '0;
          end else if (w_dma_gnt) begin
            if (r_burst_cnt != BURST_TOP)
              r_burst_cnt <= r_burst_cnt + BCW'(1);
            if (!io_bus.dma_lock)
              r_state <= S_SHARED;
          end
        end
        default: r_state <= S_SHARED;
      endcase

      if (!io_bus.dma_req || w_dma_gnt)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != STARVE_TOP)
        r_starve_cnt <= r_starve_cnt + SCW'(1);

      r_rd_pend  <= w_cpu_rd || w_dma_rd;
      r_rd_owner <= w_dma_gnt ? PORT_DMA : PORT_CPU;
    end
  end

  assign io_bus.cpu_gnt   = w_cpu_gnt;
  assign io_bus.dma_gnt   = w_dma_gnt;
  assign io_bus.cpu_stall = io_bus.cpu_req && !w_cpu_gnt;

  // Memory side: idle cycles present the CPU payload with both enables low.
  assign io_bus.mem_read_en  = w_cpu_rd || w_dma_rd;
  assign io_bus.mem_write_en = (w_cpu_gnt && io_bus.cpu_we) || (w_dma_gnt && io_bus.dma_we);
  assign io_bus.mem_address  = w_dma_gnt ? io_bus.dma_addr   : io_bus.cpu_addr;
  assign io_bus.mem_data_in  = w_dma_gnt ? io_bus.dma_wdata  : io_bus.cpu_wdata;
  assign io_bus.mem_funct3   = w_dma_gnt ? io_bus.dma_funct3 : io_bus.cpu_funct3;

  // Read return; a read in flight across reset is dropped.
  assign io_bus.cpu_rvalid = r_rd_pend && (r_rd_owner == PORT_CPU) && !i_reset;
  assign io_bus.dma_rvalid = r_rd_pend && (r_rd_owner == PORT_DMA) && !i_reset;
  assign io_bus.cpu_rdata  = io_bus.mem_data_out;
  assign io_bus.dma_rdata  = io_bus.mem_data_out;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model behind it.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .STARVE_LIMIT(4), .BURST_MAX(8)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  // Memory model: registered read with funct3 extension, sized writes.
  logic [7:0] mem [0:4095];

  function automatic logic [31:0] mem_rd(input logic [11:0] a, input logic [2:0] f);
    logic [31:0] w;
    w = {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
    case (f)
      F3_LB:   return {{24{w[7]}}, w[7:0]};
      F3_LH:   return {{16{w[15]}}, w[15:0]};
      F3_LBU:  return {24'd0, w[7:0]};
      F3_LHU:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mem_write_en) begin
      mem[bus.mem_address] <= bus.mem_data_in[7:0];
      if (bus.mem_funct3 != F3_SB) mem[bus.mem_address + 12'd1] <= bus.mem_data_in[15:8];
      if (bus.mem_funct3 == F3_SW) begin
        mem[bus.mem_address + 12'd2] <= bus.mem_data_in[23:16];
        mem[bus.mem_address + 12'd3] <= bus.mem_data_in[31:24];
      end
    end
    if (bus.mem_read_en) bus.mem_data_out <= mem_rd(bus.mem_address, bus.mem_funct3);
  end

  typedef struct {
    logic        cr, cw;
    logic [11:0] ca;
    logic [31:0] cd;
    logic [2:0]  cf;
    logic        dr, dw, dl;
    logic [11:0] da;
    logic [31:0] dd;
    logic [2:0]  df;
    logic        ecg, edg, ecv, edv;
    logic [31:0] erd;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [11:0] ca, input logic [31:0] cd, input logic [2:0] cf,
    input logic dr, input logic dw, input logic dl, input logic [11:0] da, input logic [31:0] dd,
    input logic [2:0] df, input logic ecg, input logic edg, input logic ecv, input logic edv,
    input logic [31:0] erd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.cf = cf;
    v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd; v.df = df;
    v.ecg = ecg; v.edg = edg; v.ecv = ecv; v.edv = edv; v.erd = erd;
    return v;
  endfunction

  function automatic vec_t idle(input logic ecv, input logic edv, input logic [31:0] erd);
    return mk(1'b0, 1'b0, 12'h000, 32'h0, F3_LW, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, F3_LW,
              1'b0, 1'b0, ecv, edv, erd);
  endfunction

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s got=%h exp=%h", tag, nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance past the rising edge.
  task automatic step(input string tag, input vec_t v);
    logic [11:0] ea;
    bus.cpu_req = v.cr; bus.cpu_we = v.cw; bus.cpu_addr = v.ca; bus.cpu_wdata = v.cd; bus.cpu_funct3 = v.cf;
    bus.dma_req = v.dr; bus.dma_we = v.dw; bus.dma_lock = v.dl; bus.dma_addr = v.da;
    bus.dma_wdata = v.dd; bus.dma_funct3 = v.df;
    @(negedge clk);
    ea = v.edg ? v.da : v.ca;
    chk(tag, "cpu_gnt",   32'(bus.cpu_gnt),   32'(v.ecg));
    chk(tag, "dma_gnt",   32'(bus.dma_gnt),   32'(v.edg));
    chk(tag, "cpu_stall", 32'(bus.cpu_stall), 32'(v.cr & ~v.ecg));
    chk(tag, "rd_en",     32'(bus.mem_read_en),  32'((v.ecg & ~v.cw) | (v.edg & ~v.dw)));
    chk(tag, "wr_en",     32'(bus.mem_write_en), 32'((v.ecg & v.cw) | (v.edg & v.dw)));
    chk(tag, "addr",      32'(bus.mem_address),  32'(ea));
    if (v.ecg || v.edg) begin
      chk(tag, "wdata",  bus.mem_data_in, v.edg ? v.dd : v.cd);
      chk(tag, "funct3", 32'(bus.mem_funct3), 32'(v.edg ? v.df : v.cf));
    end
    chk(tag, "cpu_rvalid", 32'(bus.cpu_rvalid), 32'(v.ecv));
    chk(tag, "dma_rvalid", 32'(bus.dma_rvalid), 32'(v.edv));
    if (v.ecv) chk(tag, "cpu_rdata", bus.cpu_rdata, v.erd);
    if (v.edv) chk(tag, "dma_rdata", bus.dma_rdata, v.erd);
    @(posedge clk);
    #1;
  endtask

  vec_t v;
  int   beats;
  logic prev_dma;

  initial begin
    bus.mem_data_out = 32'h0;

    // Directed single-port and back-to-back traffic.
    tbl.push_back(mk(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, F3_SW, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, F3_LW, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, F3_LW, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(idle(1'b1, 1'b0, 32'hDEADBEEF));
    tbl.push_back(mk(1'b1, 1'b1, 12'h004, 32'h00000080, F3_SB, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, F3_LW, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 12'h004, 32'h0, F3_LBU, 1'b1, 1'b0, 1'b0, 12'h004, 32'h0, F3_LBU, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 12'h000, 32'h0, F3_LW, 1'b1, 1'b0, 1'b0, 12'h004, 32'h0, F3_LBU, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000080));
    tbl.push_back(idle(1'b0, 1'b1, 32'h00000080));
    tbl.push_back(mk(1'b0, 1'b0, 12'h000, 32'h0, F3_LW, 1'b1, 1'b0, 1'b0, 12'h004, 32'h0, F3_LB, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(idle(1'b0, 1'b1, 32'hFFFFFF80));
    tbl.push_back(mk(1'b0, 1'b0, 12'h000, 32'h0, F3_LW, 1'b1, 1'b1, 1'b0, 12'h020, 32'h12345678, F3_SW, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, 12'h030, 32'h0000ABCD, F3_SH, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, F3_LW, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 12'h030, 32'h0, F3_LH, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, F3_LW, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(idle(1'b1, 1'b0, 32'hFFFFABCD));

    // Contention: DMA wins on cycles 4 and 9; a withdrawn DMA request restarts the count.
    prev_dma = 1'b0;
    for (int k = 0; k < 18; k++) begin
      logic dw, hasprev;
      dw = (k == 4) || (k == 9) || (k == 17);
      hasprev = (k != 0);
      v = mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, (k != 12), 1'b0, 1'b0, 12'h020, 32'h0, F3_LW,
             ~dw, dw, hasprev & ~prev_dma, hasprev & prev_dma, prev_dma ? 32'h12345678 : 32'hDEADBEEF);
      tbl.push_back(v);
      prev_dma = dw;
    end
    tbl.push_back(idle(1'b0, 1'b1, 32'h12345678));

    // Reset cycle: requests present, nothing granted or returned.
    rst = 1'b1;
    step("reset", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b0, 1'b0, 12'h020, 32'h0, F3_LW, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    step("reset2", idle(1'b0, 1'b0, 32'h0));
    rst = 1'b0;

    foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

    // Locked burst of 12 DMA stores with CPU waiting: 8 DMA, 1 CPU, 4 DMA.
    beats = 0;
    for (int i = 0; i < 13; i++) begin
      logic edg;
      edg = (i != 8);
      v = mk((i > 0), 1'b0, 12'h010, 32'h0, F3_LW, (beats < 12), 1'b1, (beats < 11),
             12'h100 + 12'(beats * 4), 32'(beats), F3_SW, ~edg, edg, (i == 9), 1'b0, 32'hDEADBEEF);
      step($sformatf("burst%0d", i), v);
      if (edg) beats++;
    end
    step("burst_end", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b1, 1'b0, 12'h200, 32'h5, F3_SW,
                         1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    step("burst_idle", idle(1'b1, 1'b0, 32'hDEADBEEF));

    // DMA bubble while locked: CPU takes the bubble, lock persists.
    step("bub_a", mk(1'b0, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b1, 1'b1, 12'h050, 32'h1, F3_SW, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    step("bub_b", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b0, 1'b1, 1'b1, 12'h054, 32'h2, F3_SW, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    step("bub_c", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b1, 1'b1, 12'h054, 32'h2, F3_SW, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF));
    step("bub_d", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b1, 1'b0, 12'h058, 32'h3, F3_SW, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    step("bub_e", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b1, 1'b0, 12'h05C, 32'h4, F3_SW, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    step("bub_f", idle(1'b1, 1'b0, 32'hDEADBEEF));

    // Reset during a locked burst with a DMA read in flight.
    step("rb0", mk(1'b0, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 12'h020, 32'h0, F3_LW, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    step("rb1", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 12'h020, 32'h0, F3_LW, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678));
    rst = 1'b1;
    step("rb_rst", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 12'h020, 32'h0, F3_LW, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 12'h020, 32'h0, F3_LW,
             (i < 4), (i == 4), (i > 0), 1'b0, 32'hDEADBEEF);
      step($sformatf("rb_post%0d", i), v);
    end
    step("rb_unlock", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b1, 1'b0, 1'b0, 12'h020, 32'h0, F3_LW,
                         1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678));
    step("rb_shared", mk(1'b1, 1'b0, 12'h010, 32'h0, F3_LW, 1'b0, 1'b0, 1'b0, 12'h020, 32'h0, F3_LW,
                         1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
